// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the two-requester add/subtract scheduler:
//   - op codes (OP_ADD / OP_SUB)
//   - condition-code bit positions and masks (CCR = {C, V, N, Z})
//   - scheduler FSM state enum
//   - round-robin grant helper used by the arbiter
// Optional feature macro used elsewhere in this slice: ALU_SCHED_CV_EN
// -----------------------------------------------------------------------------
package alu_pkg;

    // Op codes carried on req_op
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Condition code register layout
    localparam int CCR_C_BIT = 3;
    localparam int CCR_V_BIT = 2;
    localparam int CCR_N_BIT = 1;
    localparam int CCR_Z_BIT = 0;

    localparam logic [3:0] CCR_C_MASK = 4'b0001 << CCR_C_BIT;
    localparam logic [3:0] CCR_V_MASK = 4'b0001 << CCR_V_BIT;
    localparam logic [3:0] CCR_N_MASK = 4'b0001 << CCR_N_BIT;
    localparam logic [3:0] CCR_Z_MASK = 4'b0001 << CCR_Z_BIT;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FLAGS = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Round-robin pick between two requesters. With both pending the one
    // after the last winner is chosen; with a single one pending it wins
    // regardless of history. With none pending the result is a don't-care
    // because the caller gates it with the valid bit.
    function automatic logic rr_grant(input logic [1:0] valid, input logic last);
        logic g;
        if (valid[0] && valid[1]) begin
            g = ~last;
        end else if (valid[1]) begin
            g = 1'b1;
        end else begin
            g = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/alu_sched_if.sv
// -----------------------------------------------------------------------------
// alu_sched_if
// Bundles the request and response handshakes of the add/subtract scheduler.
//   req_valid[1:0] / req_ready[1:0] : per-requester handshake
//   req_op[1:0]                     : per-requester op (0 add, 1 sub)
//   req_a0/req_b0, req_a1/req_b1    : operands of requester 0 / 1
//   rsp_valid / rsp_ready           : result handshake
//   rsp_id, R, CCR                  : owner, result and {C,V,N,Z}
// Modports:
//   master : requesters + result consumer (drive requests, take results)
//   slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface alu_sched_if #(
    parameter int op_size = 4
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         req_op;
    logic [op_size-1:0] req_a0;
    logic [op_size-1:0] req_b0;
    logic [op_size-1:0] req_a1;
    logic [op_size-1:0] req_b1;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [op_size-1:0] R;
    logic [3:0]         CCR;

    modport master (
        output req_valid, req_op, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, R, CCR
    );

    modport slave (
        input  req_valid, req_op, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, R, CCR
    );

endinterface

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational add/subtract datapath with condition flags.
// Ports:
//   op      : 0 = add (a+b), 1 = sub (a-b)
//   a, b    : operands, op_size bits
//   r       : result modulo 2^op_size
//   c, v    : carry/borrow and signed overflow
//   n, z    : sign of r and r == 0
// Build option: ALU_SCHED_CV_EN
//   defined     -> c and v are computed
//   not defined -> c and v are tied low and no carry/overflow logic exists
// -----------------------------------------------------------------------------
module alu_core #(
    parameter int op_size = 4
) (
    input  logic               op,
    input  logic [op_size-1:0] a,
    input  logic [op_size-1:0] b,
    output logic [op_size-1:0] r,
    output logic               c,
    output logic               v,
    output logic               n,
    output logic               z
);
    import alu_pkg::*;

    localparam int MSB = op_size - 1;

`ifdef ALU_SCHED_CV_EN
    // One extra bit holds the carry out on add; on sub it wraps to 1 exactly
    // when a < b unsigned, which is the borrow.
    logic [op_size:0] ext_s;

    // Widened add/subtract so the carry/borrow falls out of the top bit
    always_comb begin
        ext_s = {(op_size+1){1'b0}};
        case (op)
            OP_ADD:  ext_s = {1'b0, a} + {1'b0, b};
            OP_SUB:  ext_s = {1'b0, a} - {1'b0, b};
            default: ext_s = {1'b0, a} + {1'b0, b};
        endcase
    end

    assign r = ext_s[op_size-1:0];
    assign c = ext_s[op_size];

    // Signed overflow: add overflows when like-signed operands give a result
    // of the other sign; sub when unlike-signed operands do.
    always_comb begin
        v = 1'b0;
        if (op == OP_SUB) begin
            v = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]);
        end else begin
            v = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]);
        end
    end
`else
    // Plain modular add/subtract; no carry or overflow tracking
    always_comb begin
        r = {op_size{1'b0}};
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            default: r = a + b;
        endcase
    end

    assign c = 1'b0;
    assign v = 1'b0;
`endif

    assign n = r[MSB];
    assign z = (r == {op_size{1'b0}});

endmodule

// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched
// Round-robin scheduler in front of the shared add/subtract core.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : alu_sched_if.slave (request handshakes, operands, result port)
// Sequencing per operation:
//   IDLE  -> accept one requester, latch op/A/B/id, update last winner
//   CALC  -> register R
//   FLAGS -> register CCR, raise rsp_valid
//   DONE  -> hold R/CCR/rsp_id until rsp_valid && rsp_ready
// Build option: ALU_SCHED_CV_EN (inside alu_core) enables the C and V flags;
// timing and handshake are the same either way.
// -----------------------------------------------------------------------------
module alu_sched #(
    parameter int op_size = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_sched_if.slave  bus
);
    import alu_pkg::*;

    // State and output registers
    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic               op_q, op_d;
    logic [op_size-1:0] a_q, a_d;
    logic [op_size-1:0] b_q, b_d;
    logic               id_q, id_d;
    logic [op_size-1:0] r_q, r_d;
    logic [3:0]         ccr_q, ccr_d;
    logic               rsp_valid_q, rsp_valid_d;

    // Arbiter and datapath signals
    logic               grant_s;
    logic [1:0]         req_ready_s;
    logic               accept_s;
    logic               sel_op_s;
    logic [op_size-1:0] sel_a_s;
    logic [op_size-1:0] sel_b_s;
    logic [op_size-1:0] core_r_s;
    logic               core_c_s;
    logic               core_v_s;
    logic               core_n_s;
    logic               core_z_s;

    // Shared arithmetic core always works on the latched operands, so its
    // outputs are stable through CALC and FLAGS.
    alu_core #(
        .op_size (op_size)
    ) u_core (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .r  (core_r_s),
        .c  (core_c_s),
        .v  (core_v_s),
        .n  (core_n_s),
        .z  (core_z_s)
    );

    // Arbiter: ready only in IDLE and never while reset is asserted
    always_comb begin
        grant_s     = rr_grant(bus.req_valid, last_q);
        req_ready_s = 2'b00;
        if ((state_q == ST_IDLE) && !rst && bus.req_valid[grant_s]) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = 2'b00;
        end
        accept_s = |(bus.req_valid & req_ready_s);
    end

    // Operand/op mux for the granted requester
    always_comb begin
        sel_op_s = bus.req_op[grant_s];
        if (grant_s) begin
            sel_a_s = bus.req_a1;
            sel_b_s = bus.req_b1;
        end else begin
            sel_a_s = bus.req_a0;
            sel_b_s = bus.req_b0;
        end
    end

    // Next-state and next-register computation
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        r_d         = r_q;
        ccr_d       = ccr_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    op_d    = sel_op_s;
                    a_d     = sel_a_s;
                    b_d     = sel_b_s;
                    id_d    = grant_s;
                    last_d  = grant_s;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                r_d     = core_r_s;
                state_d = ST_FLAGS;
            end
            ST_FLAGS: begin
                // rsp_valid rises together with CCR so the response is
                // visible for the handshake at the third edge after accept.
                ccr_d       = ({4{core_c_s}} & CCR_C_MASK) |
                              ({4{core_v_s}} & CCR_V_MASK) |
                              ({4{core_n_s}} & CCR_N_MASK) |
                              ({4{core_z_s}} & CCR_Z_MASK);
                rsp_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; last = 1 lets requester 0 win first
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            op_q        <= 1'b0;
            a_q         <= {op_size{1'b0}};
            b_q         <= {op_size{1'b0}};
            id_q        <= 1'b0;
            r_q         <= {op_size{1'b0}};
            ccr_q       <= 4'b0000;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            r_q         <= r_d;
            ccr_q       <= ccr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.R         = r_q;
    assign bus.CCR       = ccr_q;

endmodule

// File: tb/tb_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_sched
// Directed vectors for alu_sched. The stimulus process queues the expected
// response of every operation it issues; an independent monitor pops and
// compares on each response handshake and checks the accept-to-valid latency.
// Expected CCR values are written for the ALU_SCHED_CV_EN build and masked
// down to N/Z when the macro is absent.
// -----------------------------------------------------------------------------
module tb_alu_sched;
    import alu_pkg::*;

    localparam int W = 4;
`ifdef ALU_SCHED_CV_EN
    localparam logic [3:0] CV_MASK = 4'b1111;
`else
    localparam logic [3:0] CV_MASK = 4'b0011;
`endif

    typedef struct packed {
        logic         id;
        logic [W-1:0] r;
        logic [3:0]   ccr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks    = 0;
    int   failures  = 0;
    int   cyc       = 0;
    int   acc_edge  = -100;
    exp_t sb_q[$];

    alu_sched_if #(.op_size(W)) bus ();

    alu_sched #(.op_size(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] r, input logic [3:0] ccr);
        exp_t e;
        e.id  = id[0];
        e.r   = r;
        e.ccr = ccr & CV_MASK;
        sb_q.push_back(e);
    endtask

    // Issue one op from a single requester; called just after a rising edge.
    task automatic issue(input int id, input logic op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er, input logic [3:0] ec);
        bit seen = 1'b0;
        logic [1:0] onehot;
        onehot = (id == 0) ? 2'b01 : 2'b10;
        bus.req_op[id] = op;
        if (id == 0) begin
            bus.req_a0 = a;
            bus.req_b0 = b;
        end else begin
            bus.req_a1 = a;
            bus.req_b1 = b;
        end
        bus.req_valid[id] = 1'b1;
        push_exp(id, er, ec);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) seen = 1'b1;
        end
        check("accept_seen", {31'd0, seen}, 32'd1);
        check("grant", {30'd0, bus.req_ready}, {30'd0, onehot});
        acc_edge = cyc + 1;
        @(posedge clk);
        #1 bus.req_valid[id] = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: latency on each new response, scoreboard compare on handshake
    initial begin
        exp_t e;
        logic prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rsp_valid && !prev_v) begin
                    check("rsp_latency", cyc + 1, acc_edge + 3);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected actual R=%0h CCR=%0h required no response", bus.R, bus.CCR);
                    end else begin
                        e = sb_q.pop_front();
                        check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
                        check("R", {28'd0, bus.R}, {28'd0, e.r});
                        check("CCR", {28'd0, bus.CCR}, {28'd0, e.ccr});
                    end
                end
            end
            prev_v = bus.rsp_valid;
        end
    end

    // Stimulus
    initial begin
        int n;
        int prev_acc;
        bit done;

        rst           = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_op    = 2'b00;
        bus.req_a0    = 4'd0;
        bus.req_b0    = 4'd0;
        bus.req_a1    = 4'd0;
        bus.req_b1    = 4'd0;
        bus.rsp_ready = 1'b1;

        // Reset state, with both requesters valid
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {30'd0, bus.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_R", {28'd0, bus.R}, 32'd0);
        check("rst_CCR", {28'd0, bus.CCR}, 32'd0);
        check("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        rst           = 1'b0;

        // Single-requester vectors
        issue(0, OP_SUB, 4'd3,  4'd5, 4'b1110, 4'b1010);
        issue(1, OP_ADD, 4'd7,  4'd1, 4'b1000, 4'b0110);
        issue(0, OP_ADD, 4'd15, 4'd1, 4'b0000, 4'b1001);
        issue(1, OP_SUB, 4'd5,  4'd5, 4'b0000, 4'b0001);
        issue(1, OP_SUB, 4'd0,  4'd1, 4'b1111, 4'b1010);
        issue(0, OP_ADD, 4'd9,  4'd9, 4'b0010, 4'b1100);

        // Wait for the pipeline to drain
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        #1;

        // Reset during FLAGS: in-flight op discarded, pending req0 taken next
        bus.req_op[0] = OP_SUB;
        bus.req_a0    = 4'd3;
        bus.req_b0    = 4'd5;
        bus.req_valid = 2'b01;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) done = 1'b1;
        end
        check("rstf_accept_seen", {31'd0, done}, 32'd1);
        acc_edge = cyc + 1;
        @(posedge clk);
        #1;
        bus.req_op[0] = OP_ADD;
        bus.req_a0    = 4'd9;
        bus.req_b0    = 4'd9;
        push_exp(0, 4'b0010, 4'b1100);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("flags_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rstf_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rstf_R", {28'd0, bus.R}, 32'd0);
        check("rstf_CCR", {28'd0, bus.CCR}, 32'd0);
        check("rstf_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
        check("rstf_req_ready", {30'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstf_pending_grant", {30'd0, bus.req_ready}, 32'd1);
        acc_edge = cyc + 1;
        @(posedge clk);
        #1 bus.req_valid = 2'b00;
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);

        // Both valid continuously after reset: strict alternation, 4 edges apart
        do_reset();
        bus.req_op[0] = OP_ADD;
        bus.req_a0    = 4'd2;
        bus.req_b0    = 4'd3;
        bus.req_op[1] = OP_SUB;
        bus.req_a1    = 4'd1;
        bus.req_b1    = 4'd2;
        push_exp(0, 4'b0101, 4'b0000);
        push_exp(1, 4'b1111, 4'b1010);
        push_exp(0, 4'b0101, 4'b0000);
        push_exp(1, 4'b1111, 4'b1010);
        bus.req_valid = 2'b11;
        n        = 0;
        prev_acc = 0;
        for (int k = 0; k < 80 && n < 4; k++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                check("rr_grant", {30'd0, bus.req_ready}, (n % 2 == 0) ? 32'd1 : 32'd2);
                if (n > 0) check("rr_spacing", cyc + 1 - prev_acc, 32'd4);
                prev_acc = cyc + 1;
                acc_edge = cyc + 1;
                n++;
                if (n == 4) begin
                    @(posedge clk);
                    #1 bus.req_valid = 2'b00;
                end
            end
        end
        check("rr_accepts", n, 32'd4);
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        #1;

        // Consumer stalls for 5 cycles while requester 1 waits
        bus.rsp_ready = 1'b0;
        issue(0, OP_SUB, 4'd8, 4'd1, 4'b0111, 4'b0100);
        bus.req_op[1]    = OP_ADD;
        bus.req_a1       = 4'd9;
        bus.req_b1       = 4'd9;
        bus.req_valid[1] = 1'b1;
        push_exp(1, 4'b0010, 4'b1100);
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) done = 1'b1;
        end
        check("stall_valid_seen", {31'd0, done}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("stall_R", {28'd0, bus.R}, 32'h7);
            check("stall_CCR", {28'd0, bus.CCR}, {28'd0, 4'b0100 & CV_MASK});
            check("stall_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
            check("stall_req_ready", {30'd0, bus.req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);
        check("stall_next_grant", {30'd0, bus.req_ready}, 32'd2);
        acc_edge = cyc + 1;
        @(posedge clk);
        #1 bus.req_valid = 2'b00;

        // Everything queued must have been answered
        for (int k = 0; k < 40 && sb_q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("sb_drain", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
